// File: rtl/multi_port_reg_file.sv
// Parametrised multi-port register file with optional zero register, write-to-read
// bypass and a post-reset clear sequencer that zeroes the array one entry per cycle.
module multi_port_reg_file #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = $clog2(NUM_REGS),
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                                clk,
  input  logic                                rstN,
  input  logic [NUM_READ-1:0][ADDR_W-1:0]     readAddr,
  output logic [NUM_READ-1:0][DATA_W-1:0]     readValue,
  input  logic [NUM_WRITE-1:0]                writeEnable,
  input  logic [NUM_WRITE-1:0][ADDR_W-1:0]    writeAddr,
  input  logic [NUM_WRITE-1:0][DATA_W-1:0]    writeValue,
  output logic                                ready
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} stateT;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  stateT             stateReg, stateNext;
  logic [ADDR_W-1:0] clrIdxReg, clrIdxNext;
  logic [DATA_W-1:0] regArray [NUM_REGS];
  logic [NUM_WRITE-1:0] writeKeep;

  // Sequencer: state bit and clear counter.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      stateReg  <= CLEAR;
      clrIdxReg <= '0;
    end else begin
      stateReg  <= stateNext;
      clrIdxReg <= clrIdxNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    clrIdxNext = clrIdxReg;
    case (stateReg)
      CLEAR: begin
        clrIdxNext = clrIdxReg + ADDR_W'(1);
        if (clrIdxReg == LAST_IDX) stateNext = RUN;
      end
      default: ;
    endcase
  end

  assign ready = (stateReg == RUN);

  // Writes to entry 0 are dropped when it is the hardwired zero register.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WRITE; gi++) begin : gWriteKeep
      assign writeKeep[gi] = writeEnable[gi] &&
                             !((ZERO_REG != 0) && (writeAddr[gi] == '0));
    end
  endgenerate

  // Array has no reset; the reset edge itself performs no write. Later ports
  // overwrite earlier ones in loop order, so the highest-indexed port wins.
  always_ff @(posedge clk) begin
    if (rstN) begin
      if (stateReg == CLEAR) begin
        regArray[clrIdxReg] <= '0;
      end else begin
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (writeKeep[w]) regArray[writeAddr[w]] <= writeValue[w];
        end
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : gRead
      logic [DATA_W-1:0] rdData;

      always_comb begin
        rdData = regArray[readAddr[gi]];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUM_WRITE; w++) begin
            if (writeEnable[w] && (writeAddr[w] == readAddr[gi])) rdData = writeValue[w];
          end
        end
        if (((ZERO_REG != 0) && (readAddr[gi] == '0)) || (stateReg == CLEAR)) rdData = '0;
      end

      assign readValue[gi] = rdData;
    end
  endgenerate

endmodule

// File: tb/tb_multi_port_reg_file.sv
// Scoreboard bench: two instances (32-bit integer file with bypass and two write
// ports; 64-bit FP-style file without zero register or bypass).
module tb_multi_port_reg_file;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  // Instance A: DATA_W 32, NUM_WRITE 2, ZERO_REG 1, BYPASS 1
  logic [1:0][4:0]  aRA;
  logic [1:0][31:0] aRV;
  logic [1:0]       aWE;
  logic [1:0][4:0]  aWA;
  logic [1:0][31:0] aWV;
  logic             aReady;

  // Instance B: DATA_W 64, NUM_WRITE 1, ZERO_REG 0, BYPASS 0
  logic [1:0][4:0]  bRA;
  logic [1:0][63:0] bRV;
  logic [0:0]       bWE;
  logic [0:0][4:0]  bWA;
  logic [0:0][63:0] bWV;
  logic             bReady;

  multi_port_reg_file #(
    .DATA_W(32), .NUM_REGS(32), .NUM_READ(2), .NUM_WRITE(2), .ZERO_REG(1), .BYPASS(1)
  ) dutA (
    .clk(clk), .rstN(rstN), .readAddr(aRA), .readValue(aRV),
    .writeEnable(aWE), .writeAddr(aWA), .writeValue(aWV), .ready(aReady)
  );

  multi_port_reg_file #(
    .DATA_W(64), .NUM_REGS(32), .NUM_READ(2), .NUM_WRITE(1), .ZERO_REG(0), .BYPASS(0)
  ) dutB (
    .clk(clk), .rstN(rstN), .readAddr(bRA), .readValue(bRV),
    .writeEnable(bWE), .writeAddr(bWA), .writeValue(bWV), .ready(bReady)
  );

  typedef enum int {S_A_RV0, S_A_RV1, S_A_RDY, S_B_RV0, S_B_RV1, S_B_RDY} selT;

  typedef struct {
    string       name;
    selT         sel;
    logic [63:0] exp;
  } expT;

  expT expQ[$];
  int  compared   = 0;
  int  mismatched = 0;

  task automatic push(input string name, input selT sel, input logic [63:0] exp);
    expT e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    expQ.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] observe(input selT sel);
    case (sel)
      S_A_RV0: return {32'd0, aRV[0]};
      S_A_RV1: return {32'd0, aRV[1]};
      S_A_RDY: return {63'd0, aReady};
      S_B_RV0: return bRV[0];
      S_B_RV1: return bRV[1];
      default: return {63'd0, bReady};
    endcase
  endfunction

  // Monitor: drains every expectation queued since the last active edge.
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      expT e;
      logic [63:0] act;
      e   = expQ.pop_front();
      act = observe(e.sel);
      compared++;
      if (act !== e.exp) begin
        mismatched++;
        $display("FAIL %s: got 0x%016h expected 0x%016h", e.name, act, e.exp);
      end else begin
        $display("ok   %s: 0x%016h", e.name, act);
      end
    end
  end

  initial begin
    rstN = 1'b0;
    aRA = '0; aWE = '0; aWA = '0; aWV = '0;
    bRA = '0; bWE = '0; bWA = '0; bWV = '0;

    // Reset held for two edges
    step();
    push("rst_readyA", S_A_RDY, 64'd0);
    push("rst_readyB", S_B_RDY, 64'd0);
    step();
    rstN = 1'b1;

    // Clear sequence with an attempted write to entry 5
    aWE[0] = 1'b1; aWA[0] = 5'd5; aWV[0] = 32'hDEAD;
    bWE[0] = 1'b1; bWA[0] = 5'd5; bWV[0] = 64'hDEAD;
    aRA[0] = 5'd5; bRA[0] = 5'd5;
    for (int i = 0; i < 32; i++) begin
      push($sformatf("clr%0d_readyA", i), S_A_RDY, 64'd0);
      push($sformatf("clr%0d_readyB", i), S_B_RDY, 64'd0);
      if (i == 3) begin
        push("clr_forced0_A", S_A_RV0, 64'd0);
        push("clr_forced0_B", S_B_RV0, 64'd0);
      end
      step();
    end
    aWE = '0; bWE = '0;
    push("clr_done_readyA", S_A_RDY, 64'd1);
    push("clr_done_readyB", S_B_RDY, 64'd1);
    push("clr_e5_A", S_A_RV0, 64'd0);
    push("clr_e5_B", S_B_RV0, 64'd0);

    // Basic write/read
    step();
    aWE[0] = 1'b1; aWA[0] = 5'd7; aWV[0] = 32'h12345678;
    bWE[0] = 1'b1; bWA[0] = 5'd7; bWV[0] = 64'h12345678;
    step();
    aWE = '0; bWE = '0;
    aRA[0] = 5'd7; aRA[1] = 5'd8;
    bRA[0] = 5'd7; bRA[1] = 5'd8;
    push("basic_e7_A", S_A_RV0, 64'h12345678);
    push("basic_e8_A", S_A_RV1, 64'd0);
    push("basic_e7_B", S_B_RV0, 64'h12345678);
    push("basic_e8_B", S_B_RV1, 64'd0);

    // Zero register
    step();
    aWE[0] = 1'b1; aWA[0] = 5'd0; aWV[0] = 32'hFFFFFFFF; aRA[0] = 5'd0;
    bWE[0] = 1'b1; bWA[0] = 5'd0; bWV[0] = 64'h00000000FFFFFFFF; bRA[0] = 5'd0;
    push("zero_same_A", S_A_RV0, 64'd0);
    push("zero_same_B", S_B_RV0, 64'd0);
    step();
    aWE = '0; bWE = '0;
    push("zero_after_A", S_A_RV0, 64'd0);
    push("zero_after_B", S_B_RV0, 64'h00000000FFFFFFFF);

    // Bypass vs no bypass
    step();
    aWE[0] = 1'b1; aWA[0] = 5'd3; aWV[0] = 32'hA5A5A5A5; aRA[0] = 5'd3;
    bWE[0] = 1'b1; bWA[0] = 5'd3; bWV[0] = 64'hA5A5A5A5; bRA[0] = 5'd3;
    push("byp_same_A", S_A_RV0, 64'hA5A5A5A5);
    push("byp_same_B", S_B_RV0, 64'd0);
    step();
    aWE = '0; bWE = '0;
    push("byp_next_A", S_A_RV0, 64'hA5A5A5A5);
    push("byp_next_B", S_B_RV0, 64'hA5A5A5A5);

    // Dual-write conflict on entry 9
    step();
    aWE = 2'b11; aWA[0] = 5'd9; aWA[1] = 5'd9; aWV[0] = 32'h11; aWV[1] = 32'h22;
    aRA[0] = 5'd9; aRA[1] = 5'd9;
    push("dual_byp_p0", S_A_RV0, 64'h22);
    push("dual_byp_p1", S_A_RV1, 64'h22);
    step();
    aWE = '0;
    push("dual_after_p0", S_A_RV0, 64'h22);
    push("dual_after_p1", S_A_RV1, 64'h22);

    // Reset mid-clear
    step();
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    for (int i = 0; i < 10; i++) step();
    rstN = 1'b0;
    push("mid_rst_readyA", S_A_RDY, 64'd0);
    step();
    rstN = 1'b1;
    for (int i = 0; i < 32; i++) begin
      push($sformatf("reclr%0d_readyA", i), S_A_RDY, 64'd0);
      push($sformatf("reclr%0d_readyB", i), S_B_RDY, 64'd0);
      step();
    end
    push("reclr_done_readyA", S_A_RDY, 64'd1);
    push("reclr_done_readyB", S_B_RDY, 64'd1);
    for (int i = 0; i < 32; i++) begin
      aRA[0] = 5'(i); aRA[1] = 5'(31 - i);
      bRA[0] = 5'(i); bRA[1] = 5'(31 - i);
      push($sformatf("post_e%0d_A0", i), S_A_RV0, 64'd0);
      push($sformatf("post_e%0d_A1", 31 - i), S_A_RV1, 64'd0);
      push($sformatf("post_e%0d_B0", i), S_B_RV0, 64'd0);
      push($sformatf("post_e%0d_B1", 31 - i), S_B_RV1, 64'd0);
      step();
    end

    step();
    if (expQ.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
